// File: rtl/if_id_stage_pkg.sv
// Constants and widths shared by the pipeline registers and hazard/forwarding logic.
package if_id_stage_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000; // sll $0,$0,0

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_id_stage_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/if_id_stage.sv
// Fetch stage: PC register, next-PC select and the IF/ID pipeline register.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = if_id_stage_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = if_id_stage_pkg::NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc4_q, pc4_d;
  logic               valid_q, valid_d;

  logic              redirect;
  logic [ADDR_W-1:0] target, pc_plus4;

  assign redirect = branch_taken | jump;
  assign target   = word_align(jump ? jump_target : branch_target);
  assign pc_plus4 = pc_q + 32'd4;

  // Stall wins over redirect: the stalled ID instruction re-presents its
  // branch/jump resolution once the stall clears.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (!stall) begin
      if (redirect) begin
        pc_d    = target;
        instr_d = NOP_INSTR;
        pc4_d   = '0;
        valid_d = 1'b0;
      end else begin
        pc_d    = pc_plus4;
        instr_d = imem_rdata;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~stall & redirect),
    .count (flush_cnt)
  );
endmodule
